usb_tx_slave_fifo: RTL and testbench

Write-direction engine for the FX2 slave-FIFO bus. It drains 16-bit words from a local FPGA FIFO into the FX2 IN endpoint, strobing SLWR once per word. Full packets commit automatically. Short packets are committed with PKTEND, either on timeout or on an explicit flush. It shares FD/FIFOADR with the existing slave-FIFO read path through a request/grant pair driven by the top-level arbiter.

---
 rtl/usb_tx_slave_fifo.sv | 178 +++++++++++++++++
 tb/tb_usb_tx_slave_fifo.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_slave_fifo.sv
// usb_tx_slave_fifo
//
// Write-direction engine for the FX2 slave-FIFO bus. Drains 16-bit words from
// a local FPGA FIFO into the FX2 IN endpoint, one SLWR strobe per word. Full
// packets commit on their own when the per-packet word count wraps. Short
// packets are committed with PKTEND, either after an idle timeout or on an
// explicit flush. FD/FIFOADR are shared with the read path via bus_req/bus_gnt.
//
// Ports:
//   CLK            system clock (FX2 IFCLK domain)
//   RST            asynchronous active-low reset
//   FLAG_FULL      IN endpoint full; writes are held off while high
//   fifo_empty     local FIFO empty
//   fifo_q         local FIFO read data, valid the cycle after the read
//   flush          single-cycle request to commit a pending partial packet
//   bus_gnt        arbiter grant of FD/FIFOADR
//   fifo_rdrq      local FIFO read request, one cycle per word
//   FD_OUT         write data to the FD pins
//   FD_OE          FD output enable (top level tristates FD when low)
//   FIFOADR        endpoint select
//   SLWR           write strobe, high one cycle per word
//   PKTEND         short-packet commit, high one cycle
//   bus_req        bus request to the arbiter
//   state_monitor  current state encoding
//   words_sent     total words strobed (wraps)

module usb_tx_slave_fifo #(
  parameter logic [1:0]  EP_ADDR   = 2'b10,
  parameter int unsigned PKT_WORDS = 256,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLAG_FULL,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_q,
  input  logic        flush,
  input  logic        bus_gnt,
  output logic        fifo_rdrq,
  output logic [15:0] FD_OUT,
  output logic        FD_OE,
  output logic [1:0]  FIFOADR,
  output logic        SLWR,
  output logic        PKTEND,
  output logic        bus_req,
  output logic [2:0]  state_monitor,
  output logic [31:0] words_sent
);

  // PKT_WORDS is a power of two, so natural wrap of the counter is the modulo.
  localparam int unsigned CntW = $clog2(PKT_WORDS);
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam logic [TmrW-1:0] TimeoutVal = TmrW'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReq     = 3'd1,
    StFetch   = 3'd2,
    StLatch   = 3'd3,
    StWr      = 3'd4,
    StWrEnd   = 3'd5,
    StCommit  = 3'd6,
    StRelease = 3'd7
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] word_cnt_q;
  logic [TmrW-1:0] timer_q;
  logic            flush_pend_q;

  logic [CntW-1:0] word_cnt_inc;
  logic            cnt_nz;
  logic            cnt_inc_nz;
  logic            timed_out;

  assign word_cnt_inc  = word_cnt_q + CntW'(1);
  assign cnt_nz        = |word_cnt_q;
  assign cnt_inc_nz    = |word_cnt_inc;
  assign timed_out     = (timer_q == TimeoutVal);
  assign state_monitor = state_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      word_cnt_q   <= '0;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
      fifo_rdrq    <= 1'b0;
      FD_OUT       <= '0;
      FD_OE        <= 1'b0;
      FIFOADR      <= '0;
      SLWR         <= 1'b0;
      PKTEND       <= 1'b0;
      bus_req      <= 1'b0;
      words_sent   <= '0;
    end else begin
      PKTEND  <= 1'b0;
      timer_q <= '0;
      // A flush with nothing pending is dropped so no zero-length packet is sent.
      if (flush && cnt_nz) flush_pend_q <= 1'b1;

      case (state_q)
        StIdle: begin
          // Timer only runs while a partial packet sits with no new data.
          if (cnt_nz && fifo_empty) begin
            timer_q <= timed_out ? timer_q : timer_q + TmrW'(1);
          end
          if (!fifo_empty || flush_pend_q || (timed_out && cnt_nz)) begin
            bus_req <= 1'b1;
            state_q <= StReq;
          end
        end

        StReq: begin
          if (bus_gnt) begin
            FIFOADR <= EP_ADDR;
            FD_OE   <= 1'b1;
            if (!fifo_empty) begin
              fifo_rdrq <= 1'b1;
              state_q   <= StFetch;
            end else begin
              state_q <= StCommit;
            end
          end
        end

        StFetch: begin
          fifo_rdrq <= 1'b0;
          state_q   <= StLatch;
        end

        StLatch: begin
          FD_OUT  <= fifo_q;
          state_q <= StWr;
        end

        StWr: begin
          if (!FLAG_FULL) begin
            SLWR       <= 1'b1;
            words_sent <= words_sent + 32'd1;
            state_q    <= StWrEnd;
          end
        end

        StWrEnd: begin
          SLWR       <= 1'b0;
          word_cnt_q <= word_cnt_inc;
          // A same-cycle flush is judged against the count including this word.
          flush_pend_q <= flush_pend_q | (flush & cnt_inc_nz);
          if (!fifo_empty) begin
            fifo_rdrq <= 1'b1;
            state_q   <= StFetch;
          end else if ((flush_pend_q || flush) && cnt_inc_nz) begin
            state_q <= StCommit;
          end else begin
            state_q <= StRelease;
          end
        end

        StCommit: begin
          if (cnt_nz) PKTEND <= 1'b1;
          word_cnt_q   <= '0;
          flush_pend_q <= 1'b0;
          state_q      <= StRelease;
        end

        StRelease: begin
          FD_OE   <= 1'b0;
          bus_req <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_slave_fifo.sv
// Directed bench for usb_tx_slave_fifo: a small array-backed FIFO model feeds
// the DUT, a negedge monitor logs every SLWR/PKTEND, and the main sequence
// compares against hand-computed values.

module tb_usb_tx_slave_fifo;

  localparam int unsigned PktWords = 256;
  localparam int unsigned Timeout  = 1024;
  localparam int          LogDepth = 1024;

  logic        clk;
  logic        rst_n;
  logic        flag_full;
  logic        fifo_empty;
  logic [15:0] fifo_q;
  logic        flush;
  logic        bus_gnt;
  logic        fifo_rdrq;
  logic [15:0] fd_out;
  logic        fd_oe;
  logic [1:0]  fifoadr;
  logic        slwr;
  logic        pktend;
  logic        bus_req;
  logic [2:0]  state_mon;
  logic [31:0] words_sent;

  usb_tx_slave_fifo #(
    .EP_ADDR  (2'b10),
    .PKT_WORDS(PktWords),
    .TIMEOUT  (Timeout)
  ) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .FLAG_FULL    (flag_full),
    .fifo_empty   (fifo_empty),
    .fifo_q       (fifo_q),
    .flush        (flush),
    .bus_gnt      (bus_gnt),
    .fifo_rdrq    (fifo_rdrq),
    .FD_OUT       (fd_out),
    .FD_OE        (fd_oe),
    .FIFOADR      (fifoadr),
    .SLWR         (slwr),
    .PKTEND       (pktend),
    .bus_req      (bus_req),
    .state_monitor(state_mon),
    .words_sent   (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Local FIFO model: stimulus owns src/wr_ptr, the read process owns rd_ptr.
  logic [15:0] src [0:LogDepth-1];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rdrq && (rd_ptr != wr_ptr)) begin
      fifo_q <= src[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor
  int          cyc = 0;
  int          slwr_n = 0;
  int          pktend_n = 0;
  int          pktend_cyc = 0;
  int          stab_err = 0;
  int          oe_err = 0;
  int          coin_err = 0;
  logic [15:0] prev_fd = '0;
  logic [15:0] slwr_data [0:LogDepth-1];
  int          slwr_cyc  [0:LogDepth-1];

  always @(negedge clk) begin
    cyc++;
    if (slwr === 1'b1) begin
      if (slwr_n < LogDepth) begin
        slwr_data[slwr_n] = fd_out;
        slwr_cyc[slwr_n]  = cyc;
      end
      slwr_n++;
      if (fd_out !== prev_fd) stab_err++;
      if (fd_oe !== 1'b1) oe_err++;
      if (pktend === 1'b1) coin_err++;
    end
    if (pktend === 1'b1) begin
      pktend_n++;
      pktend_cyc = cyc;
    end
    prev_fd = fd_out;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] val);
    src[wr_ptr] = val;
    wr_ptr++;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_slwr(input string tag, input int target, input int budget);
    int n = 0;
    while (slwr_n < target && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, slwr_n, target);
  endtask

  task automatic wait_pktend(input string tag, input int target, input int budget);
    int n = 0;
    while (pktend_n < target && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, pktend_n, target);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n = 0;
    while (state_mon !== s && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, {29'd0, state_mon}, {29'd0, s});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int p0;
    int c0;
    int bad;

    rst_n     = 1'b0;
    flag_full = 1'b0;
    flush     = 1'b0;
    bus_gnt   = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_state", {29'd0, state_mon}, 32'd0);
    check_eq("rst_slwr", {31'd0, slwr}, 32'd0);
    check_eq("rst_fd_oe", {31'd0, fd_oe}, 32'd0);
    check_eq("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check_eq("rst_fifoadr", {30'd0, fifoadr}, 32'd0);
    check_eq("rst_fd_out", {16'd0, fd_out}, 32'd0);
    check_eq("rst_words", words_sent, 32'd0);
    rst_n = 1'b1;
    tick();

    // Grant withheld for 50 cycles with data pending
    push(16'h5A5A);
    push(16'hA5A5);
    tick();
    tick();
    bad = 0;
    repeat (50) begin
      if (bus_req !== 1'b1 || fd_oe !== 1'b0 || slwr !== 1'b0 || fifoadr !== 2'b00 ||
          state_mon !== 3'd1) bad++;
      tick();
    end
    check_eq("nogrant_hold", bad, 0);
    n0 = slwr_n;
    p0 = pktend_n;
    bus_gnt = 1'b1;
    c0 = cyc;
    tick();
    check_eq("grant_fifoadr", {30'd0, fifoadr}, 32'd2);
    check_eq("grant_fd_oe", {31'd0, fd_oe}, 32'd1);
    wait_slwr("grant_slwr", n0 + 1, 20);
    check_eq("grant_latency", slwr_cyc[n0] - c0, 4);
    check_eq("grant_data0", {16'd0, slwr_data[n0]}, 32'h5A5A);
    wait_slwr("grant_slwr2", n0 + 2, 20);
    check_eq("grant_data1", {16'd0, slwr_data[n0 + 1]}, 32'hA5A5);
    wait_state("grant_idle", 3'd0, 20);
    pulse_flush();
    wait_pktend("grant_flush", p0 + 1, 20);
    wait_state("grant_idle2", 3'd0, 20);
    check_eq("grant_words", words_sent, 32'd2);

    // Three words, then commit by timeout
    n0 = slwr_n;
    p0 = pktend_n;
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    wait_slwr("w3_slwr", n0 + 3, 60);
    check_eq("w3_d0", {16'd0, slwr_data[n0]}, 32'h1111);
    check_eq("w3_d1", {16'd0, slwr_data[n0 + 1]}, 32'h2222);
    check_eq("w3_d2", {16'd0, slwr_data[n0 + 2]}, 32'h3333);
    check_eq("w3_gap0", slwr_cyc[n0 + 1] - slwr_cyc[n0], 4);
    check_eq("w3_gap1", slwr_cyc[n0 + 2] - slwr_cyc[n0 + 1], 4);
    check_eq("w3_words", words_sent, 32'd5);
    wait_state("w3_idle", 3'd0, 10);
    c0 = cyc;
    check_eq("w3_no_early_pktend", pktend_n, p0);
    wait_pktend("w3_timeout", p0 + 1, Timeout + 50);
    check_eq("w3_timeout_cycles", pktend_cyc - c0, Timeout + 3);
    wait_state("w3_idle2", 3'd0, 20);

    // Full packet: wraps with no PKTEND
    n0 = slwr_n;
    p0 = pktend_n;
    for (int i = 0; i < PktWords; i++) push(16'h1000 + 16'(i));
    wait_slwr("pkt_slwr", n0 + PktWords, PktWords * 4 + 50);
    bad = 0;
    for (int i = 0; i < PktWords; i++) begin
      if (slwr_data[n0 + i] !== 16'h1000 + 16'(i)) bad++;
      if (i > 0 && slwr_cyc[n0 + i] - slwr_cyc[n0 + i - 1] != 4) bad++;
    end
    check_eq("pkt_data_gaps", bad, 0);
    check_eq("pkt_words", words_sent, 32'd261);
    wait_state("pkt_idle", 3'd0, 20);
    repeat (Timeout + 20) tick();
    check_eq("pkt_no_pktend", pktend_n, p0);
    // Flush with an empty packet: nothing should happen
    pulse_flush();
    bad = 0;
    repeat (10) begin
      if (bus_req !== 1'b0) bad++;
      tick();
    end
    check_eq("pkt_wrap_flush_idle", bad, 0);

    // Five words then flush; second flush ignored
    n0 = slwr_n;
    p0 = pktend_n;
    for (int i = 0; i < 5; i++) push(16'h0050 + 16'(i));
    wait_slwr("f5_slwr", n0 + 5, 60);
    wait_state("f5_idle", 3'd0, 20);
    pulse_flush();
    wait_pktend("f5_pktend", p0 + 1, 20);
    check_eq("f5_after_slwr", {31'd0, pktend_cyc > slwr_cyc[n0 + 4]}, 32'd1);
    wait_state("f5_idle2", 3'd0, 20);
    repeat (20) tick();
    check_eq("f5_single_pktend", pktend_n, p0 + 1);
    pulse_flush();
    bad = 0;
    repeat (20) begin
      if (bus_req !== 1'b0) bad++;
      tick();
    end
    check_eq("f5_reflush_noreq", bad, 0);
    check_eq("f5_reflush_nopktend", pktend_n, p0 + 1);
    check_eq("f5_words", words_sent, 32'd266);

    // Endpoint full during WR
    n0 = slwr_n;
    p0 = pktend_n;
    flag_full = 1'b1;
    push(16'hABCD);
    wait_state("full_wr", 3'd4, 20);
    check_eq("full_fd_out", {16'd0, fd_out}, 32'hABCD);
    bad = 0;
    repeat (20) begin
      if (slwr !== 1'b0 || fd_out !== 16'hABCD) bad++;
      tick();
    end
    check_eq("full_hold", bad, 0);
    flag_full = 1'b0;
    tick();
    check_eq("full_release_slwr", {31'd0, slwr}, 32'd1);
    check_eq("full_release_data", {16'd0, fd_out}, 32'hABCD);
    wait_state("full_idle", 3'd0, 20);
    pulse_flush();
    wait_pktend("full_pktend", p0 + 1, 20);
    wait_state("full_idle2", 3'd0, 20);
    check_eq("full_words", words_sent, 32'd267);

    // Asynchronous reset in WR
    flag_full = 1'b1;
    push(16'h1234);
    wait_state("rstwr_wr", 3'd4, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstwr_slwr", {31'd0, slwr}, 32'd0);
    check_eq("rstwr_pktend", {31'd0, pktend}, 32'd0);
    check_eq("rstwr_fd_oe", {31'd0, fd_oe}, 32'd0);
    check_eq("rstwr_bus_req", {31'd0, bus_req}, 32'd0);
    check_eq("rstwr_rdrq", {31'd0, fifo_rdrq}, 32'd0);
    check_eq("rstwr_state", {29'd0, state_mon}, 32'd0);
    check_eq("rstwr_words", words_sent, 32'd0);
    tick();
    check_eq("rstwr_state_held", {29'd0, state_mon}, 32'd0);
    rst_n = 1'b1;
    flag_full = 1'b0;
    tick();

    // Invariants gathered by the monitor
    check_eq("fd_stable_at_slwr", stab_err, 0);
    check_eq("fd_oe_at_slwr", oe_err, 0);
    check_eq("pktend_slwr_overlap", coin_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
